// File: rtl/fetch_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_ctrl_if : instruction-memory request/acknowledge bus
// Revision 1.0
// ============================================================================
interface fetch_ctrl_if;
    logic        ce;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (output ce, imem_req, imem_addr, input imem_ack);
    modport slave  (input ce, imem_req, imem_addr, output imem_ack);
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction-fetch sequencer with stall, branch and drop handling
// Optional exception redirect/flush enabled by macro FETCH_CTRL_EXC_EN
// Revision 1.0
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                branch_flag,
    input  logic [31:0]         branch_target,
`ifdef FETCH_CTRL_EXC_EN
    input  logic                exc_req,
    output logic                flush,
`endif
    fetch_ctrl_if.master        imem,
    output logic [31:0]         pc,
    output logic                if_valid,
    output logic [5:0]          stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_nx;
    logic [31:0] target;
    logic [31:0] target_nx;
    logic        exc;

`ifdef FETCH_CTRL_EXC_EN
    // Exceptions are only taken once fetching has started.
    assign exc   = exc_req && (state != IDLE);
    assign flush = exc;
`else
    logic exc_vector_unused;
    assign exc               = 1'b0;
    assign exc_vector_unused = ^EXC_VECTOR;
`endif

    assign imem.ce        = (state != IDLE);
    assign imem.imem_req  = (state == REQ) || (state == DROP);
    assign imem.imem_addr = pc;

    always_comb begin
        stall = 6'b000000;
        if (exc)
            stall = 6'b000000;
        else if (stallreq_ex)
            stall = 6'b001111;
        else if (stallreq_id)
            stall = 6'b000111;
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        target_nx = target;
        if_valid  = 1'b0;
        case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                if (exc) begin
                    if (imem.imem_ack) begin
                        pc_nx = EXC_VECTOR;
                    end else begin
                        target_nx = EXC_VECTOR;
                        state_nx  = DROP;
                    end
                end else if (imem.imem_ack) begin
                    if (branch_flag) begin
                        pc_nx = branch_target;
                    end else if (stall[1]) begin
                        state_nx = HOLD;
                    end else begin
                        if_valid = 1'b1;
                        if (!stall[0])
                            pc_nx = pc + 32'd4;
                    end
                end else if (branch_flag) begin
                    // Word still in flight: remember where to go, discard it on ack.
                    target_nx = branch_target;
                    state_nx  = DROP;
                end
            end
            HOLD: begin
                if (exc) begin
                    pc_nx    = EXC_VECTOR;
                    state_nx = REQ;
                end else if (branch_flag) begin
                    pc_nx    = branch_target;
                    state_nx = REQ;
                end else if (!stall[1]) begin
                    if_valid = 1'b1;
                    pc_nx    = pc + 32'd4;
                    state_nx = REQ;
                end
            end
            DROP: begin
                if (exc) begin
                    if (imem.imem_ack) begin
                        pc_nx    = EXC_VECTOR;
                        state_nx = REQ;
                    end else begin
                        target_nx = EXC_VECTOR;
                    end
                end else if (imem.imem_ack) begin
                    pc_nx    = branch_flag ? branch_target : target;
                    state_nx = REQ;
                end else if (branch_flag) begin
                    target_nx = branch_target;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            target <= 32'h0000_0000;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            target <= target_nx;
        end
    end

endmodule
`default_nettype wire
